// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default line timing.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   localparam int CLKS_PER_BIT_DEF = 16;
   localparam int STOP_BITS_DEF    = 1;
   localparam int DATA_BITS        = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// Down-counting bit timer: reloads to CLKS_PER_BIT-1, expires when it reaches zero.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam int            TW     = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = RELOAD;
      end else if (enable_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - TW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= RELOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tif.sv
// UART transmitter: one-byte holding register feeding an 8N1/8N2 frame shifter.
module uart_tif
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int STOP_BITS    = STOP_BITS_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_vld,
   input  logic [7:0] tx_din,
   output logic       tx_rdy,
   output logic       txd,
   output logic       busy,
   output logic       tx_done
);

   localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

   tx_state_e  state_q, state_d;
   logic       hold_full_q, hold_full_d;
   logic [7:0] hold_q, hold_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] idx_q, idx_d;
   logic       stop_idx_q, stop_idx_d;
   logic       txd_q, txd_d;
   logic       tmr_load, tmr_expire, frame_end;

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk      (clk),
      .rst      (rst),
      .load_i   (tmr_load),
      .enable_i (busy),
      .expire_o (tmr_expire)
   );

   always_comb begin
      state_d     = state_q;
      hold_full_d = hold_full_q;
      hold_d      = hold_q;
      shift_d     = shift_q;
      idx_d       = idx_q;
      stop_idx_d  = stop_idx_q;
      txd_d       = txd_q;
      tmr_load    = 1'b0;
      frame_end   = 1'b0;

      // Acceptance only when empty, so it never collides with a drain below.
      if (tx_vld && !hold_full_q) begin
         hold_d      = tx_din;
         hold_full_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            txd_d = 1'b1;
            if (hold_full_q) begin
               shift_d     = hold_q;
               hold_full_d = 1'b0;
               state_d     = START;
               txd_d       = 1'b0;
               tmr_load    = 1'b1;
            end
         end
         START: begin
            if (tmr_expire) begin
               state_d  = DATA;
               idx_d    = 3'd0;
               txd_d    = shift_q[0];
               tmr_load = 1'b1;
            end
         end
         DATA: begin
            if (tmr_expire) begin
               tmr_load = 1'b1;
               shift_d  = shift_q >> 1;
               if (idx_q == LAST_IDX) begin
                  state_d    = STOP;
                  stop_idx_d = 1'b0;
                  txd_d      = 1'b1;
               end else begin
                  idx_d = idx_q + 3'd1;
                  txd_d = shift_q[1];
               end
            end
         end
         STOP: begin
            if (tmr_expire) begin
               tmr_load = 1'b1;
               if (stop_idx_q == LAST_STOP) begin
                  frame_end = 1'b1;
                  // A waiting byte starts its frame with no idle gap.
                  if (hold_full_q) begin
                     shift_d     = hold_q;
                     hold_full_d = 1'b0;
                     state_d     = START;
                     txd_d       = 1'b0;
                  end else begin
                     state_d = IDLE;
                     txd_d   = 1'b1;
                  end
               end else begin
                  stop_idx_d = stop_idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         hold_full_q <= 1'b0;
         shift_q     <= 8'h00;
         idx_q       <= 3'd0;
         stop_idx_q  <= 1'b0;
         txd_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         idx_q       <= idx_d;
         stop_idx_q  <= stop_idx_d;
         txd_q       <= txd_d;
      end
   end

   // Holding data is only meaningful while hold_full is set.
   always_ff @(posedge clk) begin
      hold_q <= hold_d;
   end

   assign tx_rdy  = ~hold_full_q;
   assign txd     = txd_q;
   assign busy    = (state_q != IDLE);
   assign tx_done = frame_end;

endmodule

// File: tb/tb_uart_tif.sv
// Bench for uart_tif: directed frames, a serial-line scoreboard monitor, and an 8N2 instance.
module tb_uart_tif;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_vld, tx_vld2;
   logic [7:0] tx_din, tx_din2;
   logic       tx_rdy, txd, busy, tx_done;
   logic       tx_rdy2, txd2, busy2, tx_done2;

   int vecs = 0;
   int errs = 0;

   logic [7:0] sb_q[$];

   always #5 clk = ~clk;

   uart_tif dut (
      .clk     (clk),
      .rst     (rst),
      .tx_vld  (tx_vld),
      .tx_din  (tx_din),
      .tx_rdy  (tx_rdy),
      .txd     (txd),
      .busy    (busy),
      .tx_done (tx_done)
   );

   uart_tif #(
      .CLKS_PER_BIT(8),
      .STOP_BITS   (2)
   ) dut2 (
      .clk     (clk),
      .rst     (rst),
      .tx_vld  (tx_vld2),
      .tx_din  (tx_din2),
      .tx_rdy  (tx_rdy2),
      .txd     (txd2),
      .busy    (busy2),
      .tx_done (tx_done2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected line level i cycles after acceptance, default timing, i in 1..160.
   function automatic logic exp_txd(input logic [7:0] b, input int i);
      if (i < 1 || i > 160) return 1'b1;
      if (i <= 16) return 1'b0;
      if (i <= 144) return b[(i - 17) / 16];
      return 1'b1;
   endfunction

   // Monitor: decode frames from txd at mid-bit and compare against the scoreboard.
   bit         m_in = 1'b0;
   int         m_cnt = 0;
   logic [7:0] m_byte;
   logic       m_start, m_stop;
   logic [7:0] m_exp;

   always @(negedge clk) begin
      if (rst) begin
         m_in = 1'b0;
      end else if (m_in) begin
         m_cnt++;
         if (m_cnt == 8) m_start = txd;
         if (m_cnt >= 24 && m_cnt <= 136 && ((m_cnt - 24) % 16) == 0)
            m_byte[(m_cnt - 24) / 16] = txd;
         if (m_cnt == 152) m_stop = txd;
         if (m_cnt == 159) begin
            m_in = 1'b0;
            if (sb_q.size() == 0) begin
               check("sb_unexpected_frame", 32'({m_start, m_stop, tx_done, m_byte}), 32'hFFF);
            end else begin
               m_exp = sb_q.pop_front();
               check("sb_frame", 32'({m_start, m_stop, tx_done, m_byte}),
                     32'({1'b0, 1'b1, 1'b1, m_exp}));
            end
         end
      end else if (txd == 1'b0) begin
         m_in    = 1'b1;
         m_cnt   = 0;
         m_byte  = 8'h00;
         m_start = 1'b1;
         m_stop  = 1'b0;
      end
   end

   task automatic send(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      tx_vld = 1'b1;
      tx_din = b;
      while (tx_rdy !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("send_rdy_wait", 32'(n >= 1000), 32'd0);
      @(posedge clk);
      #1 tx_vld = 1'b0;
   endtask

   task automatic check_frame(input logic [7:0] b, input string tag);
      int bad_txd = 0;
      int bad_done = 0;
      int bad_busy = 0;
      for (int i = 0; i <= 161; i++) begin
         @(negedge clk);
         if (txd !== exp_txd(b, i)) bad_txd++;
         if (tx_done !== (i == 160)) bad_done++;
         if (busy !== (i >= 1 && i <= 160)) bad_busy++;
      end
      check({tag, "_txd_wave"}, 32'(bad_txd), 32'd0);
      check({tag, "_done_pulse"}, 32'(bad_done), 32'd0);
      check({tag, "_busy"}, 32'(bad_busy), 32'd0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy !== 1'b0 || sb_q.size() != 0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("idle_wait", 32'(n >= 2000), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad_w, bad_d, bad_b, bad_r;
      logic exp;

      rst     = 1'b1;
      tx_vld  = 1'b0;
      tx_din  = 8'h00;
      tx_vld2 = 1'b0;
      tx_din2 = 8'h00;
      #3;
      check("rst_outputs", 32'({txd, tx_rdy, busy, tx_done}), 32'b1100);
      check("rst_outputs2", 32'({txd2, tx_rdy2, busy2, tx_done2}), 32'b1100);
      repeat (3) @(negedge clk);
      check("rst_held", 32'({txd, tx_rdy, busy, tx_done}), 32'b1100);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single 0x55 frame
      sb_q.push_back(8'h55);
      send(8'h55);
      check_frame(8'h55, "f55");
      wait_idle();

      // Back-to-back 0xA5 / 0x3C
      sb_q.push_back(8'hA5);
      send(8'hA5);
      bad_w = 0; bad_d = 0; bad_b = 0; bad_r = 0;
      for (int c = 0; c <= 321; c++) begin
         @(negedge clk);
         if (c >= 1 && c <= 160)        exp = exp_txd(8'hA5, c);
         else if (c >= 161 && c <= 320) exp = exp_txd(8'h3C, c - 160);
         else                           exp = 1'b1;
         if (txd !== exp) bad_w++;
         if (tx_done !== (c == 160 || c == 320)) bad_d++;
         if (busy !== (c >= 1 && c <= 320)) bad_b++;
         if (c >= 41 && c <= 160 && tx_rdy !== 1'b0) bad_r++;
         if (c == 161) check("b2b_rdy_rise", 32'(tx_rdy), 32'd1);
         if (c == 40) begin
            sb_q.push_back(8'h3C);
            tx_vld = 1'b1;
            tx_din = 8'h3C;
         end
         if (c == 41) tx_vld = 1'b0;
      end
      check("b2b_txd_wave", 32'(bad_w), 32'd0);
      check("b2b_done", 32'(bad_d), 32'd0);
      check("b2b_busy", 32'(bad_b), 32'd0);
      check("b2b_rdy_low", 32'(bad_r), 32'd0);
      wait_idle();

      // Holding register full: 0xFF must be ignored
      sb_q.push_back(8'h12);
      send(8'h12);
      bad_r = 0;
      for (int c = 0; c <= 165; c++) begin
         @(negedge clk);
         if (c >= 31 && c <= 150 && tx_rdy !== 1'b0) bad_r++;
         if (c == 161) check("full_rdy_after_drain", 32'(tx_rdy), 32'd1);
         if (c == 20) begin
            sb_q.push_back(8'h34);
            tx_vld = 1'b1;
            tx_din = 8'h34;
         end
         if (c == 21) tx_vld = 1'b0;
         if (c == 30) begin
            tx_vld = 1'b1;
            tx_din = 8'hFF;
         end
         if (c == 150) tx_vld = 1'b0;
      end
      check("full_rdy_low", 32'(bad_r), 32'd0);
      wait_idle();

      // Reset mid-frame with a held byte; neither may survive
      send(8'h3C);
      for (int c = 0; c <= 70; c++) begin
         @(negedge clk);
         if (c == 30) begin
            tx_vld = 1'b1;
            tx_din = 8'h99;
         end
         if (c == 31) tx_vld = 1'b0;
      end
      check("pre_rst_busy", 32'(busy), 32'd1);
      #1 rst = 1'b1;
      #1 check("rst_async_mid", 32'({txd, busy, tx_rdy, tx_done}), 32'b1010);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bad_b = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (busy !== 1'b0 || txd !== 1'b1) bad_b++;
      end
      check("rst_discard_held", 32'(bad_b), 32'd0);
      sb_q.push_back(8'h81);
      send(8'h81);
      check_frame(8'h81, "f81");
      wait_idle();

      // 8N2 at 8 clocks per bit, byte 0x00
      @(negedge clk);
      tx_vld2 = 1'b1;
      tx_din2 = 8'h00;
      @(posedge clk);
      #1 tx_vld2 = 1'b0;
      bad_w = 0; bad_d = 0; bad_b = 0;
      for (int i = 0; i <= 90; i++) begin
         @(negedge clk);
         if (txd2 !== !(i >= 1 && i <= 72)) bad_w++;
         if (tx_done2 !== (i == 88)) bad_d++;
         if (busy2 !== (i >= 1 && i <= 88)) bad_b++;
      end
      check("sb2_txd_wave", 32'(bad_w), 32'd0);
      check("sb2_done", 32'(bad_d), 32'd0);
      check("sb2_busy", 32'(bad_b), 32'd0);

      repeat (4) @(negedge clk);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/uart_tif.md
UART_TIF -- requirements
Module: uart_tif

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (legal range 4..255).
REQ-002 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal values 1 or 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port tx_vld, input, 1 bit: tx_din holds a byte to send.
REQ-006 The block SHALL have port tx_din, input, 8 bits: byte to transmit.
REQ-007 The block SHALL have port tx_rdy, output, 1 bit: the holding register can accept a byte.
REQ-008 The block SHALL have port txd, output, 1 bit: serial line, idle high.
REQ-009 The block SHALL have port busy, output, 1 bit: a frame is on the line (state not IDLE).
REQ-010 The block SHALL have port tx_done, output, 1 bit: one-cycle pulse at the end of each frame's last stop bit.

Function
REQ-011 A byte SHALL be accepted on a rising edge where tx_vld=1 and tx_rdy=1, and is then written into an 8-bit holding register.
REQ-012 tx_rdy SHALL equal the inverse of the hold_full flag, so tx_vld is ignored and tx_din is not sampled while the holding register is full.
REQ-013 The FSM SHALL have four states: IDLE, START, DATA and STOP.
REQ-014 In IDLE with hold_full=1, the FSM SHALL copy the holding register into the shifter on the next edge, clear hold_full, and enter START.
  - txd goes low one cycle after acceptance.
REQ-015 Each bit SHALL last exactly CLKS_PER_BIT cycles.
  - The bit timer loads CLKS_PER_BIT-1 on every bit entry.
  - It decrements each cycle.
  - The bit ends when the timer is 0.
REQ-016 In START, txd SHALL be 0; at the end of the bit the FSM SHALL enter DATA with the bit index at 0.
REQ-017 In DATA, txd SHALL equal shifter[0] (LSB first).
  - At each bit end the shifter shifts right and the 3-bit index increments.
  - After index 7 the FSM enters STOP.
REQ-018 In STOP, txd SHALL be 1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-019 At the end of STOP, tx_done SHALL pulse high for exactly one cycle.
  - If hold_full=1, the FSM goes directly to START, reloading the shifter with no idle gap between frames.
  - Otherwise it goes to IDLE.
REQ-020 A frame SHALL last exactly (9+STOP_BITS)*CLKS_PER_BIT cycles: 160 cycles for the defaults.
REQ-021 Acceptance and a holding-register drain on the same edge SHALL NOT occur, because tx_rdy=0 whenever hold_full=1.
  - After a drain, tx_rdy rises on the following cycle.
REQ-022 txd SHALL be registered and glitch-free.
  - In IDLE, txd is 1.
  - busy is 1 exactly while the state is START, DATA or STOP.

Reset
REQ-023 When rst=1, the block SHALL immediately (asynchronously) force:
  - state=IDLE and txd=1,
  - tx_rdy=1, busy=0 and tx_done=0,
  - hold_full=0, shifter=0, bit index=0 and timer=CLKS_PER_BIT-1.
REQ-024 Reset asserted mid-frame SHALL abort the frame and discard any held byte; after reset release, the first accepted byte starts a complete new frame.

Structure
REQ-025 The state enum (IDLE, START, DATA, STOP) and the default constants (CLKS_PER_BIT=16, STOP_BITS=1) SHALL live in shared package uart_pkg for use by the other UART blocks.
REQ-026 The bit timer SHALL be a separate sub-module, uart_bit_timer.
  - Inputs: load and enable.
  - Output: expire.
  - Width: $clog2(CLKS_PER_BIT).
  - The FSM, holding register and shifter stay in uart_tif.

Verification
REQ-027 Default parameters, send 0x55:
  - txd is 0 for 16 cycles starting 1 cycle after acceptance.
  - Then the bits 1,0,1,0,1,0,1,0 follow, 16 cycles each, then the stop bit 1 for 16 cycles.
  - tx_done pulses at cycle 160; busy then falls.
REQ-028 Back-to-back 0xA5 then 0x3C:
  - The second byte is accepted while the first frame is in DATA, and tx_rdy then stays 0.
  - The second start bit begins on the cycle right after the first stop bit ends.
  - Total time is 320 cycles with no idle high gap.
REQ-029 Holding register full (frame in progress, hold_full=1):
  - Drive tx_vld=1 with 0xFF.
  - The byte is not accepted, and the next frame carries the previously held byte unchanged.
REQ-030 Reset mid-frame:
  - Assert rst at cycle 70 of a 0x3C frame.
  - txd=1 and busy=0 in the same cycle, without waiting for a clock edge.
  - After release, 0x81 transmits as a correct 160-cycle frame.
REQ-031 STOP_BITS=2, CLKS_PER_BIT=8, send 0x00:
  - txd is low for 72 cycles (start plus 8 data bits), then high for 16 cycles.
  - tx_done pulses at cycle 88.
